// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmit serializer with a baud down-count-free bit timer and optional byte FIFO.
// Define UART_TX_FIFO_EN to compile in the FIFO_DEPTH-entry queue in front of the shifter.
module uart_tx_serializer #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          bit_end;
  logic          handshake;
  logic          pending;
  logic          load;
  logic [7:0]    load_data;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign handshake = tx_valid & ready_q;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(FIFO_DEPTH);

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign fifo_empty = (count_q == '0);
  // With nothing queued, an accepted byte bypasses the FIFO straight into the shifter.
  assign pending    = !fifo_empty || handshake;
  assign load_data  = fifo_empty ? tx_data : mem_q[rptr_q];
  assign pop        = load && !fifo_empty;
  assign push       = handshake && !(load && fifo_empty);
  assign count_d    = count_q + CNTW'(push) - CNTW'(pop);
  assign ready_d    = (count_d != FULL);
  assign busy_d     = (state_d != IDLE) || (count_d != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= tx_data;
  end
`else
  logic unused_cfg;

  assign pending    = handshake;
  assign load_data  = tx_data;
  assign ready_d    = (state_d == IDLE);
  assign busy_d     = (state_d != IDLE);
  assign unused_cfg = load | (FIFO_DEPTH == 0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (pending) begin
          load    = 1'b1;
          state_d = START;
          shift_d = load_data;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Reloading from the last stop cycle keeps consecutive frames gap-free.
          if (pending) begin
            load    = 1'b1;
            state_d = START;
            shift_d = load_data;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: random and directed traffic against a frame-level line model.
// Builds with or without UART_TX_FIFO_EN; expectations follow the same macro.
module tb_uart_tx_serializer;

  localparam int CD_A    = 4;
  localparam int DEPTH_A = 4;
  localparam int CD_B    = 2;
  localparam int FRAME_A = 10 * CD_A;
  localparam int LOGN    = 4096;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif
  localparam int GAP_A = FIFO_ON ? 0 : 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_ready, a_txd, a_busy;
  logic       b_valid, b_ready, b_txd, b_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit         mon_en = 1'b0;
  int         base = 0;
  int         last_len = 0;
  int         mon_t;
  logic       log_txd   [LOGN];
  logic       log_busy  [LOGN];
  logic       log_ready [LOGN];
  int         acc_t [$];
  logic [7:0] acc_b [$];
  logic [7:0] drv_q [$];

  uart_tx_serializer #(.CLK_DIV(CD_A), .FIFO_DEPTH(DEPTH_A)) u_dut_a (
    .clk(clk), .rst(rst_n), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .txd(a_txd), .busy(a_busy)
  );

  uart_tx_serializer #(.CLK_DIV(CD_B)) u_dut_b (
    .clk(clk), .rst(rst_n), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .txd(b_txd), .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs mid-cycle; a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_t = cyc - base;
      if (mon_t >= 0 && mon_t < LOGN) begin
        log_txd[mon_t]   = a_txd;
        log_busy[mon_t]  = a_busy;
        log_ready[mon_t] = a_ready;
      end
      if (a_valid && a_ready) begin
        acc_t.push_back(mon_t + 1);
        acc_b.push_back(a_data);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic begin_window();
    acc_t.delete();
    acc_b.delete();
    base   = cyc;
    mon_en = 1'b1;
  endtask

  // Frames start at their accept edge, or right after the previous frame (plus the idle gap).
  task automatic check_window(input string tag, input int len);
    int   st [$];
    int   s_i;
    int   q;
    bit   in_f;
    logic e_txd, e_busy, e_ready;
    for (int i = 0; i < acc_t.size(); i++) begin
      s_i = acc_t[i];
      if (i > 0 && s_i < st[i-1] + FRAME_A + GAP_A) s_i = st[i-1] + FRAME_A + GAP_A;
      st.push_back(s_i);
    end
    for (int t = 0; t < len; t++) begin
      e_txd = 1'b1;
      in_f  = 1'b0;
      q     = 0;
      for (int i = 0; i < st.size(); i++) begin
        if (t >= st[i] && t < st[i] + FRAME_A) begin
          in_f  = 1'b1;
          e_txd = frame_bit(acc_b[i], (t - st[i]) / CD_A);
        end
        if (acc_t[i] <= t) q++;
        if (st[i] <= t) q--;
      end
      e_busy  = in_f || (q > 0);
      e_ready = FIFO_ON ? (q < DEPTH_A) : !in_f;
      check_val($sformatf("%s txd t=%0d", tag, t), log_txd[t], e_txd);
      check_val($sformatf("%s busy t=%0d", tag, t), log_busy[t], e_busy);
      check_val($sformatf("%s ready t=%0d", tag, t), log_ready[t], e_ready);
    end
  endtask

  task automatic finish_window(input string tag, input int n_exp);
    int budget;
    budget = 3000;
    do begin
      @(negedge clk);
      budget--;
    end while (a_busy && budget > 0);
    check_val({tag, " idle_timeout"}, budget > 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    mon_en   = 1'b0;
    last_len = cyc - base;
    if (last_len > LOGN) last_len = LOGN;
    check_window(tag, last_len);
    check_val({tag, " n_accepts"}, acc_t.size(), n_exp);
  endtask

  // Call at posedge+1; returns at posedge+1 after the last byte is accepted.
  task automatic drive_all(input int max_gap);
    int budget;
    int gap;
    bit hs;
    budget = 5000;
    while (drv_q.size() > 0 && budget > 0) begin
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      a_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
        a_data = 8'($urandom);
      end
      a_data  = drv_q[0];
      a_valid = 1'b1;
      do begin
        @(negedge clk);
        hs = a_ready;
        @(posedge clk);
        #1;
        budget--;
      end while (!hs && budget > 0);
      if (hs) void'(drv_q.pop_front());
    end
    a_valid = 1'b0;
    check_val("drive_timeout", budget > 0, 1'b1);
  endtask

  task automatic reset_mid(input logic [7:0] b, input int k);
    a_data  = b;
    a_valid = 1'b1;
    @(negedge clk);
    check_val("rst_mid pre_ready", a_ready, 1'b1);
    @(posedge clk);
    #1;
    a_data = 8'h99;
    repeat (k) @(posedge clk);
    #2;
    check_val($sformatf("rst_mid pre_txd k=%0d", k), a_txd, frame_bit(b, k / CD_A));
    check_val("rst_mid pre_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid txd", a_txd, 1'b1);
    check_val("rst_mid busy", a_busy, 1'b0);
    check_val("rst_mid ready", a_ready, 1'b0);
    a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    begin_window();
    repeat (60) @(posedge clk);
    #1;
    finish_window("post_rst_idle", 0);
  endtask

  initial begin
    int first_low;
    int n_before;
    rst_n   = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'hAA;
    b_valid = 1'b0;
    b_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset txd", a_txd, 1'b1);
    check_val("reset ready", a_ready, 1'b0);
    check_val("reset busy", a_busy, 1'b0);
    check_val("reset b_txd", b_txd, 1'b1);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready before first edge", a_ready, 1'b0);
    @(posedge clk);
    #1;
    check_val("ready after first edge", a_ready, 1'b1);
    check_val("b ready after first edge", b_ready, 1'b1);

    begin_window();
    repeat (20) @(posedge clk);
    #1;
    finish_window("idle_after_reset", 0);

    begin_window();
    drv_q = '{8'h55};
    drive_all(0);
    finish_window("byte_55", 1);

    begin_window();
    drv_q = '{8'h00, 8'hFF};
    drive_all(0);
    finish_window("pair_00_ff", 2);

    begin_window();
    drv_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    drive_all(0);
    finish_window("burst_01_06", 6);
    first_low = -1;
    for (int t = 0; t < last_len; t++)
      if (first_low < 0 && !log_ready[t]) first_low = t;
    n_before = 0;
    for (int i = 0; i < acc_t.size(); i++)
      if (acc_t[i] <= first_low) n_before++;
    check_val("accepts before ready drop", n_before, FIFO_ON ? DEPTH_A + 1 : 1);

    begin_window();
    drv_q = '{8'h12};
    drive_all(0);
    repeat (10) @(posedge clk);
    #1;
    a_data = 8'h34;
    finish_window("hold_12", 1);

    begin_window();
    for (int i = 0; i < 10; i++) drv_q.push_back(8'($urandom));
    drive_all(0);
    finish_window("rand_burst", 10);

    begin_window();
    for (int i = 0; i < 12; i++) drv_q.push_back(8'($urandom));
    drive_all(45);
    finish_window("rand_gaps", 12);

    reset_mid(8'hA5, 15);
    begin_window();
    drv_q = '{8'h3C};
    drive_all(0);
    finish_window("after_rst_3c", 1);

    reset_mid(8'h00, 5);

    b_data  = 8'h80;
    b_valid = 1'b1;
    @(negedge clk);
    check_val("b ready", b_ready, 1'b1);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    for (int j = 0; j < 10 * CD_B; j++) begin
      @(negedge clk);
      check_val($sformatf("b80 txd j=%0d", j), b_txd, frame_bit(8'h80, j / CD_B));
    end
    @(negedge clk);
    check_val("b80 txd after", b_txd, 1'b1);
    check_val("b80 busy after", b_busy, 1'b0);
    check_val("b80 ready after", b_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
